// File: rtl/dlx_id_ex_stage.sv
// dlx_id_ex_stage: ID->EX pipeline register with load-use interlock, EX hold and nullify bubbles
//   Optional macro DLX_IDEX_PERF_CNT_EN enables the stall_cnt/flush_cnt counters (else tied to 0).
//   Ports:
//     clk, reset_n       clock, synchronous active-low reset
//     id_*               decoded instruction fields from ID
//     nullify            kill the ID instruction (taken jump resolved in EX)
//     ex_hold            EX/MEM cannot accept; freeze EX register and stall ID
//     id_stall           IF/ID must hold this cycle
//     pc_target_id       id_pc + id_imm (combinational)
//     ex_*               registered EX copies of the id_* fields
//     stall_cnt          interlock bubble count
//     flush_cnt          nullify count
module dlx_id_ex_stage #(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int CTRL_W   = 16,
    parameter int LOAD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_is_load,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [XLEN-1:0]   id_pc,
    input  logic              nullify,
    input  logic              ex_hold,
    output logic              id_stall,
    output logic [XLEN-1:0]   pc_target_id,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_is_load,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [XLEN-1:0]   ex_imm,
    output logic [XLEN-1:0]   ex_pc,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
);
    typedef enum logic {RUN, INTERLOCK} state_t;
    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       hazard, bubble, issue;
    assign pc_target_id = id_pc + id_imm;
    // Register 0 is hard-wired zero, so a load to it never creates a dependency.
    assign hazard = id_valid & ex_valid & ex_is_load & (ex_rd != '0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        id_stall  = 1'b0;
        bubble    = 1'b0;
        issue     = 1'b0;
        if (!reset_n) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
        end else if (nullify) begin
            bubble    = 1'b1;
            state_nxt = RUN;
            cnt_nxt   = '0;
        end else if (ex_hold) begin
            id_stall  = 1'b1;
        end else if (state == INTERLOCK) begin
            id_stall  = 1'b1;
            bubble    = 1'b1;
            cnt_nxt   = cnt - 3'd1;
            state_nxt = (cnt == 3'd1) ? RUN : INTERLOCK;
        end else if (hazard) begin
            // The hazard edge itself is the first bubble; INTERLOCK covers the remaining LOAD_LAT-1.
            id_stall  = 1'b1;
            bubble    = 1'b1;
            state_nxt = (LOAD_LAT > 1) ? INTERLOCK : RUN;
            cnt_nxt   = (LOAD_LAT > 1) ? 3'(LOAD_LAT - 1) : '0;
        end else begin
            issue     = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
        if (!reset_n || bubble) begin
            ex_valid   <= 1'b0;
            ex_rs1     <= '0;
            ex_rs2     <= '0;
            ex_rd      <= '0;
            ex_is_load <= 1'b0;
            ex_ctrl    <= '0;
            ex_imm     <= '0;
            ex_pc      <= '0;
        end else if (issue) begin
            ex_valid   <= id_valid;
            ex_rs1     <= id_rs1;
            ex_rs2     <= id_rs2;
            ex_rd      <= id_rd;
            ex_is_load <= id_is_load;
            ex_ctrl    <= id_ctrl;
            ex_imm     <= id_imm;
            ex_pc      <= id_pc;
        end
    end
`ifdef DLX_IDEX_PERF_CNT_EN
    logic [31:0] stall_q, flush_q;
    logic        ilk;
    // Interlock bubbles only; nullify and hold bubbles are not counted here.
    assign ilk = reset_n & ~nullify & ~ex_hold & ((state == INTERLOCK) | hazard);
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_q + {31'd0, ilk};
            flush_q <= flush_q + {31'd0, nullify};
        end
    end
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_dlx_id_ex_stage.sv
// tb_dlx_id_ex_stage: table-driven check of dlx_id_ex_stage with LOAD_LAT=1 and LOAD_LAT=3 instances
module tb_dlx_id_ex_stage;
    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic [4:0]  rd;
        logic        ld;
        logic [31:0] pc;
    } instr_t;
    typedef struct packed {
        logic   rn;
        logic   v;
        logic   nul;
        logic   hold;
        instr_t i;
        logic   stall;
        logic   ev;
        instr_t e;
    } vec_t;

    logic        clk;
    vec_t        a, b;
    logic [31:0] imm_a, imm_b;
    int          total, passed;

    logic        s1, ev1, ld1, s3, ev3, ld3;
    logic [4:0]  rs1_1, rs2_1, rd1, rs1_3, rs2_3, rd3;
    logic [15:0] ctrl1, ctrl3;
    logic [31:0] imm1, pc1, tgt1, sc1, fc1, imm3, pc3, tgt3, sc3, fc3;

    dlx_id_ex_stage #(.LOAD_LAT(1)) dut1 (
        .clk(clk), .reset_n(a.rn), .id_valid(a.v), .id_rs1(a.i.rs1), .id_rs2(a.i.rs2),
        .id_use_rs1(a.i.u1), .id_use_rs2(a.i.u2), .id_rd(a.i.rd), .id_is_load(a.i.ld),
        .id_ctrl(a.i.pc[15:0]), .id_imm(imm_a), .id_pc(a.i.pc), .nullify(a.nul), .ex_hold(a.hold),
        .id_stall(s1), .pc_target_id(tgt1), .ex_valid(ev1), .ex_rs1(rs1_1), .ex_rs2(rs2_1),
        .ex_rd(rd1), .ex_is_load(ld1), .ex_ctrl(ctrl1), .ex_imm(imm1), .ex_pc(pc1),
        .stall_cnt(sc1), .flush_cnt(fc1)
    );
    dlx_id_ex_stage #(.LOAD_LAT(3)) dut3 (
        .clk(clk), .reset_n(b.rn), .id_valid(b.v), .id_rs1(b.i.rs1), .id_rs2(b.i.rs2),
        .id_use_rs1(b.i.u1), .id_use_rs2(b.i.u2), .id_rd(b.i.rd), .id_is_load(b.i.ld),
        .id_ctrl(b.i.pc[15:0]), .id_imm(imm_b), .id_pc(b.i.pc), .nullify(b.nul), .ex_hold(b.hold),
        .id_stall(s3), .pc_target_id(tgt3), .ex_valid(ev3), .ex_rs1(rs1_3), .ex_rs2(rs2_3),
        .ex_rd(rd3), .ex_is_load(ld3), .ex_ctrl(ctrl3), .ex_imm(imm3), .ex_pc(pc3),
        .stall_cnt(sc3), .flush_cnt(fc3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic instr_t ins(int rs1, int rs2, bit u1, bit u2, int rd, bit ld, logic [31:0] pc);
        return '{rs1: 5'(rs1), rs2: 5'(rs2), u1: u1, u2: u2, rd: 5'(rd), ld: ld, pc: pc};
    endfunction

    function automatic vec_t vv(bit rn, bit v, bit nul, bit hold, instr_t i, bit stall, bit ev, instr_t e);
        return '{rn: rn, v: v, nul: nul, hold: hold, i: i, stall: stall, ev: ev, e: e};
    endfunction

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%h want=%h", n, got, exp);
    endtask

    // Immediate is the PC rotated by 16 so every field of an issued instruction is distinct from a bubble.
    task automatic step(input bit d3, input vec_t t, input int row);
        string p;
        p = $sformatf("lat%0d row%0d", d3 ? 3 : 1, row);
        if (d3) begin b = t; imm_b = {t.i.pc[15:0], t.i.pc[31:16]}; end
        else begin a = t; imm_a = {t.i.pc[15:0], t.i.pc[31:16]}; end
        #1;
        chk({p, " id_stall"}, 32'(d3 ? s3 : s1), 32'(t.stall));
        @(posedge clk);
        #1;
        chk({p, " ex_valid"}, 32'(d3 ? ev3 : ev1), 32'(t.ev));
        chk({p, " ex_rs1"}, 32'(d3 ? rs1_3 : rs1_1), 32'(t.e.rs1));
        chk({p, " ex_rs2"}, 32'(d3 ? rs2_3 : rs2_1), 32'(t.e.rs2));
        chk({p, " ex_rd"}, 32'(d3 ? rd3 : rd1), 32'(t.e.rd));
        chk({p, " ex_is_load"}, 32'(d3 ? ld3 : ld1), 32'(t.e.ld));
        chk({p, " ex_ctrl"}, 32'(d3 ? ctrl3 : ctrl1), 32'(t.e.pc[15:0]));
        chk({p, " ex_imm"}, d3 ? imm3 : imm1, {t.e.pc[15:0], t.e.pc[31:16]});
        chk({p, " ex_pc"}, d3 ? pc3 : pc1, t.e.pc);
    endtask

    instr_t bub, lw100, add104, sub108, lw0, add0, lw114, add118, sub11c, sub120, lw120, add124;
    vec_t   t1[16];
    vec_t   t3[20];
    logic [31:0] es1, ef1, es3, ef3;

    initial begin
        total = 0;
        passed = 0;
        a = '0;
        b = '0;
        imm_a = '0;
        imm_b = '0;
        bub    = '0;
        lw100  = ins(1, 0, 1, 0, 3, 1, 32'h100);
        add104 = ins(3, 5, 1, 1, 4, 0, 32'h104);
        sub108 = ins(7, 8, 1, 1, 6, 0, 32'h108);
        lw0    = ins(1, 0, 1, 0, 0, 1, 32'h10C);
        add0   = ins(0, 0, 1, 1, 9, 0, 32'h110);
        lw114  = ins(1, 0, 1, 0, 3, 1, 32'h114);
        add118 = ins(3, 5, 1, 1, 4, 0, 32'h118);
        sub11c = ins(7, 8, 1, 1, 6, 0, 32'h11C);
        sub120 = ins(7, 8, 1, 1, 6, 0, 32'h120);
        lw120  = ins(2, 0, 1, 0, 3, 1, 32'h120);
        add124 = ins(5, 3, 1, 1, 4, 0, 32'h124);

        t1 = '{
            vv(0, 1, 0, 0, lw100,  0, 0, bub),
            vv(0, 1, 0, 0, lw100,  0, 0, bub),
            vv(1, 1, 0, 0, lw100,  0, 1, lw100),
            vv(1, 1, 0, 0, add104, 1, 0, bub),
            vv(1, 1, 0, 0, add104, 0, 1, add104),
            vv(1, 1, 0, 0, sub108, 0, 1, sub108),
            vv(1, 1, 0, 0, lw0,    0, 1, lw0),
            vv(1, 1, 0, 0, add0,   0, 1, add0),
            vv(1, 1, 0, 0, lw114,  0, 1, lw114),
            vv(1, 1, 0, 1, add118, 1, 1, lw114),
            vv(1, 1, 0, 1, add118, 1, 1, lw114),
            vv(1, 1, 0, 0, add118, 1, 0, bub),
            vv(1, 1, 0, 0, add118, 0, 1, add118),
            vv(1, 1, 1, 0, sub11c, 0, 0, bub),
            vv(1, 1, 1, 1, sub11c, 0, 0, bub),
            vv(1, 0, 0, 0, sub120, 0, 0, sub120)
        };
        t3 = '{
            vv(0, 1, 0, 0, lw100,  0, 0, bub),
            vv(0, 1, 0, 0, lw100,  0, 0, bub),
            vv(1, 1, 0, 0, lw100,  0, 1, lw100),
            vv(1, 1, 0, 0, add104, 1, 0, bub),
            vv(1, 1, 0, 0, add104, 1, 0, bub),
            vv(1, 1, 0, 0, add104, 1, 0, bub),
            vv(1, 1, 0, 0, add104, 0, 1, add104),
            vv(1, 1, 0, 0, lw0,    0, 1, lw0),
            vv(1, 1, 0, 0, add0,   0, 1, add0),
            vv(1, 1, 0, 0, lw114,  0, 1, lw114),
            vv(1, 1, 0, 0, add118, 1, 0, bub),
            vv(1, 1, 1, 0, add118, 0, 0, bub),
            vv(1, 1, 0, 0, sub11c, 0, 1, sub11c),
            vv(1, 1, 0, 0, lw120,  0, 1, lw120),
            vv(1, 1, 0, 1, add124, 1, 1, lw120),
            vv(1, 1, 0, 1, add124, 1, 1, lw120),
            vv(1, 1, 0, 0, add124, 1, 0, bub),
            vv(1, 1, 0, 0, add124, 1, 0, bub),
            vv(1, 1, 0, 0, add124, 1, 0, bub),
            vv(1, 1, 0, 0, add124, 0, 1, add124)
        };

`ifdef DLX_IDEX_PERF_CNT_EN
        es1 = 32'd2; ef1 = 32'd2; es3 = 32'd7; ef3 = 32'd1;
`else
        es1 = '0; ef1 = '0; es3 = '0; ef3 = '0;
`endif

        for (int r = 0; r < 16; r++) step(1'b0, t1[r], r);
        chk("lat1 stall_cnt", sc1, es1);
        chk("lat1 flush_cnt", fc1, ef1);

        a.i.pc = 32'hFFFF_FFFC;
        imm_a = 32'd8;
        #1;
        chk("pc_target wrap", tgt1, 32'h0000_0004);
        a.i.pc = 32'h0000_1000;
        imm_a = 32'hFFFF_FFF0;
        #1;
        chk("pc_target negative imm", tgt1, 32'h0000_0FF0);

        for (int r = 0; r < 20; r++) step(1'b1, t3[r], r);
        chk("lat3 stall_cnt", sc3, es3);
        chk("lat3 flush_cnt", fc3, ef3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/dlx_id_ex_stage.md
Name: dlx_id_ex_stage

Overview:
Parametrised ID→EX pipeline stage for the DLX pipeline. Registers decoded instruction fields into EX and computes the ID-stage jump target. Adds a load-use interlock with configurable load latency, a downstream EX hold, and bubble insertion on nullify. Sits between the decoder output and the EX/ALU stage.

Parameters:
XLEN, 32, datapath width for PC, immediate and target
REG_AW, 5, register index width
CTRL_W, 16, width of opaque decoded control bundle passed to EX
LOAD_LAT, 1, bubbles inserted per load-use hazard (legal 1..4)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
id_valid  in  1  decoder output holds a real instruction
id_rs1  in  REG_AW  source register 1
id_rs2  in  REG_AW  source register 2
id_use_rs1  in  1  instruction reads rs1
id_use_rs2  in  1  instruction reads rs2
id_rd  in  REG_AW  destination register
id_is_load  in  1  instruction is a load
id_ctrl  in  CTRL_W  decoded control bundle
id_imm  in  XLEN  sign-extended immediate
id_pc  in  XLEN  PC of instruction in ID
nullify  in  1  taken jump resolved in EX; kill ID instruction
ex_hold  in  1  EX/MEM cannot accept a new instruction
id_stall  out  1  IF/ID must hold its contents this cycle
pc_target_id  out  XLEN  id_pc + id_imm, combinational
ex_valid, ex_rs1, ex_rs2, ex_rd, ex_is_load, ex_ctrl, ex_imm, ex_pc  out  (matching widths)  registered EX copies
stall_cnt  out  32  interlock bubble count (see Optional Feature)
flush_cnt  out  32  nullify count (see Optional Feature)

Behaviour:
- Reset: reset_n=0 at a clk edge zeroes all ex_* outputs, sets state RUN, clears the bubble counter. id_stall=0 while in reset.
- pc_target_id: combinational, mod 2^XLEN, independent of state.
- Bubble: all ex_* outputs 0, ex_valid=0.
- Hazard (comb): id_valid & ex_valid & ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)). Register 0 never causes a hazard.
- Update priority per edge: reset > nullify > ex_hold > interlock > normal issue.
- nullify=1: EX loads a bubble; state→RUN; counter cleared; id_stall=0. This also applies when ex_hold=1.
- ex_hold=1 (no nullify): all ex_* outputs hold; id_stall=1; state and counter frozen.
- RUN, hazard=1: EX loads a bubble; id_stall=1. If LOAD_LAT=1, stay in RUN. Otherwise go to INTERLOCK with cnt=LOAD_LAT-1.
- INTERLOCK: id_stall=1; EX loads a bubble; cnt decrements each edge. The edge with cnt==1 returns to RUN. The instruction issues on the next RUN edge unless a new hazard exists.
- RUN, no hazard: EX loads the id_* fields; ex_valid=id_valid; id_stall=0.
- Total bubbles per load-use hazard = exactly LOAD_LAT.
- Latency ID→EX: 1 cycle when no stall.

Optional Feature:
Macro DLX_IDEX_PERF_CNT_EN.
- Defined: stall_cnt increments on every edge where EX loads an interlock bubble. flush_cnt increments on every edge with nullify=1 (and reset_n=1). Both are 32-bit, wrap at 2^32, and reset to 0.
- Not defined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with id_valid=1 → all ex_* = 0, id_stall=0. Release → first instruction appears on ex_* 1 cycle later.
- Load-use, LOAD_LAT=1: LW r3 then ADD r4,r3,r5 → ADD held with id_stall=1 for 1 cycle, EX sees one bubble, then ADD with ex_rd=4.
- Load-use, LOAD_LAT=3: same sequence → exactly 3 bubbles and id_stall high 3 cycles. A load to r0 followed by a use of r0 → 0 bubbles.
- Nullify during INTERLOCK (LOAD_LAT=3, after bubble 1) → EX bubble, state RUN, id_stall=0 that cycle. Next valid instruction issues with no residual stall.
- ex_hold=1 for 2 cycles with EX holding a load and ID holding a dependent instruction → ex_* unchanged, id_stall=1. After release, interlock proceeds with full LOAD_LAT bubbles.
- pc_target_id: id_pc=0xFFFF_FFFC, id_imm=8 → 0x0000_0004. With the macro defined, stall_cnt and flush_cnt match the counts from the scenarios above.
